ber_test_ctrl: RTL and testbench
================================

// Module: ber_test_ctrl
// PURPOSE
//  Run controller for the BER tester. Sequences one measurement around the per-word comparator.
//  Enables the pattern generator/checker. Waits for PRBS lock: SYNC_LEN consecutive error-free
//  words. Then accumulates compared bits and errored bits over a programmed window of words.
//  Reports done, lock status, sync failure and the final counts to the host/status logic.
// PARAMETERS
//  WIDTH         8     bits per compared word (comparator bus width)
//  CNT_W         32    width of err_count / bit_count / window
//  SYNC_LEN      16    consecutive zero-error words required to declare lock
//  SYNC_TIMEOUT  1024  max cycles spent in SYNC before the run fails
//  ERR_W         $clog2(WIDTH+1)  width of per-word error count (derived, not overridable)
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      single-cycle pulse; begin a run (honoured in IDLE and DONE only)
//  abort       in   1      single-cycle pulse; terminate run in SYNC/MEASURE
//  window      in   CNT_W  number of words to measure, latched on accepted start
//  word_valid  in   1      comparator result valid this cycle
//  word_err    in   ERR_W  errored bits in current word (popcount of A^B)
//  gen_en      out  1      generator/checker enable, high in SYNC and MEASURE
//  busy        out  1      high in SYNC and MEASURE
//  locked      out  1      high in MEASURE and held in DONE if lock was reached
//  done        out  1      level, high in DONE until next accepted start or rst
//  sync_fail   out  1      high in DONE when SYNC timed out
//  err_count   out  CNT_W  accumulated errored bits (saturating)
//  bit_count   out  CNT_W  accumulated compared bits (saturating)
// BEHAVIOUR
//  - rst: state=IDLE; all outputs 0; internal run/timeout/word counters 0. Reset takes effect in any state.
//  - States: IDLE, SYNC, MEASURE, DONE. All outputs are registered.
//  - IDLE/DONE + start: next state SYNC; latch window.
//    Same edge clears err_count, bit_count, locked, sync_fail, done, run and timeout counters.
//  - start while busy is ignored. An abort in IDLE or DONE is ignored.
//  - SYNC: each word_valid with word_err==0 increments run. Nonzero word_err resets run to 0.
//    The timeout counter increments every cycle.
//    - run reaches SYNC_LEN: next state MEASURE, locked=1. Words seen in SYNC are never counted.
//    - timeout reaches SYNC_TIMEOUT without lock: next state DONE, sync_fail=1, locked=0, counts 0.
//    - Lock and timeout on the same cycle: lock wins.
//  - MEASURE: each word_valid adds WIDTH to bit_count and word_err to err_count.
//    word_err > WIDTH is clamped to WIDTH. Each add saturates at 2^CNT_W-1; no wrap.
//    The internal word counter increments per valid word.
//    - The edge that accepts word number `window` updates the counts and enters DONE together.
//      done and the final counts become visible in the same cycle, 1 cycle after the last word.
//    - window==0: enters DONE on the first MEASURE cycle with zero counts and locked=1.
//  - abort in SYNC/MEASURE: next state IDLE; gen_en, busy, done=0; counts hold their last values.
//    abort beats a same-cycle word (that word is not counted) and beats lock/timeout.
//  - Latency: counts are updated 1 cycle after word_valid. gen_en drops 1 cycle after leaving MEASURE.
// TESTING
//  1. rst; start window=4; 16 clean words then err=1,0,8,2 -> locked after word 16;
//     done=1, err_count=11, bit_count=32, sync_fail=0.
//  2. 10 clean, 1 word err=3, 16 clean, window=2 clean -> lock after word 27;
//     err_count=0, bit_count=16.
//  3. word_err=1 on every cycle -> done=1 and sync_fail=1 at 1024 cycles after start;
//     locked=0, counts 0.
//  4. window=10; abort after 2 measured words, with word_valid also high that cycle -> IDLE;
//     busy=0, done=0, bit_count=16.
//  5. CNT_W=8, window=40, all err=8 -> err_count=255, bit_count=255 (saturated); done=1.
//  6. start during MEASURE is ignored (window not relatched); rst mid-MEASURE -> all outputs 0
//     next cycle; new start runs normally.

Source files
------------

// File: rtl/ber_test_ctrl_if.sv
// Host/comparator-facing bundle of the BER run controller.
// word_valid qualifies word_err for one cycle; there is no backpressure.
interface ber_test_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32
);
  localparam int ERR_W = $clog2(WIDTH + 1);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] window;
  logic             word_valid;
  logic [ERR_W-1:0] word_err;
  logic             gen_en;
  logic             busy;
  logic             locked;
  logic             done;
  logic             sync_fail;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;
  logic [1:0]       state;

  modport master (
    output start, abort, window, word_valid, word_err,
    input  gen_en, busy, locked, done, sync_fail, err_count, bit_count, state
  );

  modport slave (
    input  start, abort, window, word_valid, word_err,
    output gen_en, busy, locked, done, sync_fail, err_count, bit_count, state
  );
endinterface

// File: rtl/ber_test_ctrl.sv
// BER measurement sequencer: waits for PRBS lock, then accumulates bit and
// error counts over a programmed window of compared words.
module ber_test_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 32,
  parameter int SYNC_LEN     = 16,
  parameter int SYNC_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  ber_test_ctrl_if.slave bus
);
  localparam int ERR_W = $clog2(WIDTH + 1);
  localparam int RUN_W = $clog2(SYNC_LEN + 1);
  localparam int TO_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, SYNC, MEASURE, DONE} state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [ERR_W-1:0] err_clamp;
  logic [SUM_W-1:0] err_sum, bit_sum;

  // A corrupted comparator count can exceed the word width; never credit more than WIDTH.
  assign err_clamp = (bus.word_err > ERR_W'(WIDTH)) ? ERR_W'(WIDTH) : bus.word_err;
  assign err_sum   = {1'b0, err_q} + SUM_W'(err_clamp);
  assign bit_sum   = {1'b0, bits_q} + SUM_W'(WIDTH);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    to_d     = to_q;
    win_d    = win_q;
    words_d  = words_q;
    err_d    = err_q;
    bits_d   = bits_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    done_d   = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = SYNC;
          win_d    = bus.window;
          run_d    = '0;
          to_d     = '0;
          words_d  = '0;
          err_d    = '0;
          bits_d   = '0;
          locked_d = 1'b0;
          fail_d   = 1'b0;
          done_d   = 1'b0;
        end
      end
      SYNC: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
          if (bus.word_valid) run_d = (bus.word_err == '0) ? run_q + 1'b1 : '0;
          // Lock is tested first so a lock on the timeout cycle still wins.
          if (run_d == RUN_W'(SYNC_LEN)) begin
            state_d  = MEASURE;
            locked_d = 1'b1;
          end else if (to_d == TO_W'(SYNC_TIMEOUT)) begin
            state_d  = DONE;
            fail_d   = 1'b1;
            done_d   = 1'b1;
            locked_d = 1'b0;
            err_d    = '0;
            bits_d   = '0;
          end
        end
      end
      MEASURE: begin
        if (bus.abort) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end else if (win_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (bus.word_valid) begin
          words_d = words_q + 1'b1;
          err_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          bits_d  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
          if (words_d == win_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SYNC) || (state_d == MEASURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      run_q    <= '0;
      to_q     <= '0;
      win_q    <= '0;
      words_q  <= '0;
      err_q    <= '0;
      bits_q   <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      to_q     <= to_d;
      win_q    <= win_d;
      words_q  <= words_d;
      err_q    <= err_d;
      bits_q   <= bits_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gen_en    = busy_q;
  assign bus.busy      = busy_q;
  assign bus.locked    = locked_q;
  assign bus.done      = done_q;
  assign bus.sync_fail = fail_q;
  assign bus.err_count = err_q;
  assign bus.bit_count = bits_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_ber_test_ctrl.sv
// Bench for ber_test_ctrl: directed scenarios plus randomized word streams
// scored against a per-run behavioural model.
module tb_ber_test_ctrl;
  localparam int WIDTH        = 8;
  localparam int CNT_W        = 32;
  localparam int SYNC_LEN     = 16;
  localparam int SYNC_TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ber_test_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) a_if ();
  ber_test_ctrl_if #(.WIDTH(WIDTH), .CNT_W(8))     b_if ();

  ber_test_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SYNC_LEN(SYNC_LEN), .SYNC_TIMEOUT(SYNC_TIMEOUT))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));
  ber_test_ctrl #(.WIDTH(WIDTH), .CNT_W(8), .SYNC_LEN(SYNC_LEN), .SYNC_TIMEOUT(SYNC_TIMEOUT))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int checks = 0;
  int errors = 0;
  int vld_q[$];
  int err_q[$];
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input int v, input int e);
    for (int i = 0; i < n; i++) begin
      vld_q.push_back(v);
      err_q.push_back(e);
    end
  endtask

  task automatic gen_random(input int len, input int err_pct);
    vld_q.delete();
    err_q.delete();
    for (int i = 0; i < len; i++) begin
      vld_q.push_back(int'($urandom_range(0, 3) != 0));
      err_q.push_back(($urandom_range(0, 99) < err_pct) ? int'($urandom_range(1, 15)) : 0);
    end
  endtask

  // Reference: word k of the stream is seen on edge k+1 after the start edge.
  task automatic model_run(input longint win);
    int     run = 0;
    int     lock_at = -1;
    int     done_at = -1;
    longint words = 0;
    longint e = 0;
    longint n;
    longint cap;
    bit     fail;
    for (int t = 1; t <= SYNC_TIMEOUT && lock_at < 0; t++) begin
      if (t <= vld_q.size() && vld_q[t-1] != 0) run = (err_q[t-1] == 0) ? run + 1 : 0;
      if (run == SYNC_LEN) lock_at = t;
    end
    fail = (lock_at < 0);
    if (fail) done_at = SYNC_TIMEOUT;
    else if (win == 0) done_at = lock_at + 1;
    else begin
      for (int t = lock_at + 1; t <= vld_q.size() && done_at < 0; t++) begin
        if (vld_q[t-1] != 0) begin
          words++;
          e += (err_q[t-1] > WIDTH) ? WIDTH : err_q[t-1];
          if (words == win) done_at = t;
        end
      end
    end
    n   = words * WIDTH;
    cap = (longint'(1) << CNT_W) - 1;
    if (e > cap) e = cap;
    if (n > cap) n = cap;
    exp_q.push_back(longint'(done_at));
    exp_q.push_back(longint'(lock_at));
    exp_q.push_back(e);
    exp_q.push_back(n);
    exp_q.push_back(longint'(!fail));
    exp_q.push_back(longint'(fail));
  endtask

  task automatic play(input logic [31:0] win, input int max_cycles,
                      output int done_at, output int lock_at, output int busy_cnt);
    done_at  = -1;
    lock_at  = -1;
    busy_cnt = 0;
    a_if.start      = 1'b1;
    a_if.window     = win;
    a_if.word_valid = 1'b0;
    a_if.word_err   = '0;
    tick();
    a_if.start = 1'b0;
    chk("start_flags", {a_if.done, a_if.locked, a_if.sync_fail, a_if.busy, a_if.gen_en}, 5'b00011);
    chk("start_counts", {a_if.err_count, a_if.bit_count}, 64'd0);
    for (int t = 1; t <= max_cycles; t++) begin
      if (t <= vld_q.size()) begin
        a_if.word_valid = (vld_q[t-1] != 0);
        a_if.word_err   = 4'(err_q[t-1]);
      end else begin
        a_if.word_valid = 1'b0;
        a_if.word_err   = '0;
      end
      tick();
      if (a_if.locked && lock_at < 0) lock_at = t;
      if (a_if.done) begin
        done_at = t;
        break;
      end
      if (a_if.busy) busy_cnt++;
    end
    a_if.word_valid = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [31:0] win);
    int done_at, lock_at, busy_cnt;
    model_run(longint'(win));
    play(win, vld_q.size() + 50, done_at, lock_at, busy_cnt);
    chk({tag, "_done_at"}, longint'(done_at), exp_q.pop_front());
    chk({tag, "_lock_at"}, longint'(lock_at), exp_q.pop_front());
    chk({tag, "_err"}, a_if.err_count, exp_q.pop_front());
    chk({tag, "_bits"}, a_if.bit_count, exp_q.pop_front());
    chk({tag, "_locked"}, a_if.locked, exp_q.pop_front());
    chk({tag, "_sync_fail"}, a_if.sync_fail, exp_q.pop_front());
    chk({tag, "_idle_outs"}, {a_if.busy, a_if.gen_en}, 2'b00);
    chk({tag, "_busy_cycles"}, busy_cnt, (done_at > 0) ? done_at - 1 : busy_cnt + 1);
  endtask

  task automatic word_a(input int v, input int e);
    a_if.word_valid = (v != 0);
    a_if.word_err   = 4'(e);
    tick();
    a_if.word_valid = 1'b0;
  endtask

  initial begin
    a_if.start = 0; a_if.abort = 0; a_if.window = '0; a_if.word_valid = 0; a_if.word_err = '0;
    b_if.start = 0; b_if.abort = 0; b_if.window = '0; b_if.word_valid = 0; b_if.word_err = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_a_flags", {a_if.gen_en, a_if.busy, a_if.locked, a_if.done, a_if.sync_fail}, 5'b0);
    chk("rst_a_counts", {a_if.err_count, a_if.bit_count}, 64'd0);
    chk("rst_b_all", {b_if.gen_en, b_if.busy, b_if.locked, b_if.done, b_if.sync_fail,
                      b_if.err_count, b_if.bit_count}, 21'd0);
    rst = 1'b0;
    tick();

    // Lock after 16 clean words, then measure 1,0,8,2.
    vld_q.delete(); err_q.delete();
    push_words(16, 1, 0);
    push_words(1, 1, 1); push_words(1, 1, 0); push_words(1, 1, 8); push_words(1, 1, 2);
    run_case("t1", 4);
    chk("t1_err_lit", a_if.err_count, 11);
    chk("t1_bits_lit", a_if.bit_count, 32);
    chk("t1_done_lit", {a_if.done, a_if.locked, a_if.sync_fail}, 3'b110);

    // An errored word restarts the clean run.
    vld_q.delete(); err_q.delete();
    push_words(10, 1, 0); push_words(1, 1, 3); push_words(16, 1, 0); push_words(2, 1, 0);
    run_case("t2", 2);
    chk("t2_err_lit", a_if.err_count, 0);
    chk("t2_bits_lit", a_if.bit_count, 16);

    // Never clean: sync timeout.
    vld_q.delete(); err_q.delete();
    push_words(1100, 1, 1);
    run_case("t3", 5);
    chk("t3_fail_lit", {a_if.done, a_if.sync_fail, a_if.locked}, 3'b110);

    // Lock lands exactly on the timeout cycle, and one cycle too late.
    vld_q.delete(); err_q.delete();
    push_words(1008, 1, 1); push_words(17, 1, 0);
    run_case("lock_at_to", 1);
    vld_q.delete(); err_q.delete();
    push_words(1009, 1, 1); push_words(20, 1, 0);
    run_case("lock_late", 1);

    // Zero window, with errored words offered in measure that must not count.
    vld_q.delete(); err_q.delete();
    push_words(16, 1, 0); push_words(5, 1, 3);
    run_case("win0", 0);

    // Abort in MEASURE with a same-cycle word.
    a_if.start = 1'b1; a_if.window = 10; tick(); a_if.start = 1'b0;
    for (int i = 0; i < 16; i++) word_a(1, 0);
    chk("t4_locked", a_if.locked, 1'b1);
    word_a(1, 1);
    word_a(1, 2);
    a_if.abort = 1'b1;
    word_a(1, 5);
    a_if.abort = 1'b0;
    chk("t4_flags", {a_if.busy, a_if.gen_en, a_if.done}, 3'b000);
    chk("t4_bits", a_if.bit_count, 16);
    chk("t4_err", a_if.err_count, 3);
    a_if.abort = 1'b1;
    tick();
    a_if.abort = 1'b0;
    chk("idle_abort_ignored", {a_if.busy, a_if.done, a_if.bit_count}, {2'b00, 32'd16});

    // start during MEASURE must not relatch the window.
    a_if.start = 1'b1; a_if.window = 3; tick(); a_if.start = 1'b0;
    for (int i = 0; i < 16; i++) word_a(1, 0);
    a_if.start = 1'b1; a_if.window = 7;
    word_a(1, 0);
    a_if.start = 1'b0;
    word_a(1, 0);
    chk("t6_mid", {a_if.done, a_if.busy}, 2'b01);
    word_a(1, 0);
    chk("t6_done", {a_if.done, a_if.busy}, 2'b10);
    chk("t6_bits", a_if.bit_count, 24);

    // Reset mid-MEASURE.
    a_if.start = 1'b1; a_if.window = 5; tick(); a_if.start = 1'b0;
    for (int i = 0; i < 16; i++) word_a(1, 0);
    word_a(1, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_flags", {a_if.gen_en, a_if.busy, a_if.locked, a_if.done, a_if.sync_fail}, 5'b0);
    chk("t6_rst_counts", {a_if.err_count, a_if.bit_count}, 64'd0);
    gen_random(200, 5);
    run_case("after_rst", 6);

    // Saturation with an 8-bit counter.
    b_if.start = 1'b1; b_if.window = 40; tick(); b_if.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_if.word_valid = 1'b1; b_if.word_err = 0; tick();
    end
    for (int i = 0; i < 40; i++) begin
      b_if.word_valid = 1'b1; b_if.word_err = 8; tick();
      if (i == 30) chk("t5_pre_sat", {b_if.err_count, b_if.bit_count}, {8'd248, 8'd248});
      if (i == 31) chk("t5_sat_edge", {b_if.err_count, b_if.bit_count}, {8'd255, 8'd255});
    end
    b_if.word_valid = 1'b0;
    chk("t5_final", {b_if.done, b_if.locked, b_if.err_count, b_if.bit_count}, {2'b11, 8'd255, 8'd255});

    // Randomized runs, back to back from DONE.
    for (int r = 0; r < 8; r++) begin
      gen_random(1400, (r % 2 == 0) ? 8 : 3);
      run_case($sformatf("rnd%0d", r), 32'($urandom_range(0, 20)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
